// File: rtl/bin_to_bcd_seq.sv
// Sequential signed-binary to 3-digit BCD converter (shift-and-add-3) for the display path.
// Minus sign is 4'hF, blank digit is 4'hA, and an out-of-range value shows as "---" (12'hFFF).
module bin_to_bcd_seq #(
    parameter int IN_W     = 11,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            i_start,
    input  logic [IN_W-1:0] i_bin,
    output logic            o_busy,
    output logic            o_done,
    output logic [11:0]     o_bcd,
    output logic            o_ovf,
    output logic            o_ce
);

    localparam int CNT_W = ($clog2(IN_W + 1) < 4) ? 4 : $clog2(IN_W + 1);
    localparam logic signed [IN_W-1:0] MIN_V = IN_W'(-99);
    localparam logic signed [IN_W-1:0] MAX_V = IN_W'(999);
    localparam logic [3:0] BLANK = 4'hA;
    localparam logic [3:0] MINUS = 4'hF;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state, state_nxt;
    logic              sign;
    logic              valid;
    logic [IN_W-1:0]   mag;
    logic [11:0]       bcd;
    logic [CNT_W-1:0]  cnt;

    logic              in_range;
    logic [IN_W-1:0]   abs_in;
    logic [11:0]       adj;
    logic [11:0]       bcd_shift;
    logic [IN_W-1:0]   mag_shift;
    logic [11:0]       fmt;

    assign in_range = ($signed(i_bin) >= MIN_V) && ($signed(i_bin) <= MAX_V);
    // The most negative input maps to 2^(IN_W-1), which still fits as an unsigned IN_W value.
    assign abs_in   = i_bin[IN_W-1] ? (~i_bin + IN_W'(1)) : i_bin;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        bcd_shift = {adj[10:0], mag[IN_W-1]};
        mag_shift = {mag[IN_W-2:0], 1'b0};
    end

    // Digit substitution: sign, leading-zero blanking and the overflow pattern.
    always_comb begin
        fmt = bcd;
        if (!valid) begin
            fmt = {MINUS, MINUS, MINUS};
        end else if (sign) begin
            if (BLANK_LZ && bcd[7:4] == 4'd0) fmt = {BLANK, MINUS, bcd[3:0]};
            else                              fmt = {MINUS, bcd[7:0]};
        end else if (BLANK_LZ && bcd[11:8] == 4'd0) begin
            fmt[11:8] = BLANK;
            if (bcd[7:4] == 4'd0) fmt[7:4] = BLANK;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(IN_W - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sign   <= 1'b0;
            valid  <= 1'b0;
            mag    <= '0;
            bcd    <= '0;
            cnt    <= '0;
            o_done <= 1'b0;
            o_bcd  <= {BLANK, BLANK, BLANK};
            o_ovf  <= 1'b0;
            o_ce   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: if (i_start) begin
                    sign  <= i_bin[IN_W-1];
                    valid <= in_range;
                    mag   <= abs_in;
                    bcd   <= '0;
                    cnt   <= '0;
                end
                SHIFT: begin
                    bcd <= bcd_shift;
                    mag <= mag_shift;
                    cnt <= cnt + CNT_W'(1);
                end
                DONE: begin
                    o_bcd  <= fmt;
                    o_ovf  <= !valid;
                    o_done <= 1'b1;
                    o_ce   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed corner values plus random values, checked against an
// arithmetic model on two instances (leading-zero blanking on and off) sharing one stimulus.
module tb_bin_to_bcd_seq;

    localparam int IN_W = 11;
    localparam int LAT  = IN_W + 1;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic            i_start = 1'b0;
    logic [IN_W-1:0] i_bin = '0;
    logic            busy_a, done_a, ovf_a, ce_a;
    logic            busy_b, done_b, ovf_b, ce_b;
    logic [11:0]     bcd_a, bcd_b;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    bin_to_bcd_seq #(.IN_W(IN_W), .BLANK_LZ(1'b1)) dut_a (
        .CLK(CLK), .RST(RST), .i_start(i_start), .i_bin(i_bin),
        .o_busy(busy_a), .o_done(done_a), .o_bcd(bcd_a), .o_ovf(ovf_a), .o_ce(ce_a)
    );

    bin_to_bcd_seq #(.IN_W(IN_W), .BLANK_LZ(1'b0)) dut_b (
        .CLK(CLK), .RST(RST), .i_start(i_start), .i_bin(i_bin),
        .o_busy(busy_b), .o_done(done_b), .o_bcd(bcd_b), .o_ovf(ovf_b), .o_ce(ce_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Display pattern from decimal digits; bit 12 is the overflow flag.
    function automatic logic [12:0] model(input int v, input bit blz);
        int m, d2, d1, d0;
        logic [3:0] h, t, o;
        if (v < -99 || v > 999) return {1'b1, 12'hFFF};
        m  = (v < 0) ? -v : v;
        d2 = m / 100;
        d1 = (m / 10) % 10;
        d0 = m % 10;
        o  = 4'(d0);
        t  = 4'(d1);
        h  = 4'(d2);
        if (v < 0) begin
            if (blz && m < 10) return {1'b0, 4'hA, 4'hF, o};
            return {1'b0, 4'hF, t, o};
        end
        if (blz && m < 100) h = 4'hA;
        if (blz && m < 10)  t = 4'hA;
        return {1'b0, h, t, o};
    endfunction

    // Called at a falling edge. poke_at >= 1 pulses a second start that must be ignored;
    // b2b leaves the task in the o_done cycle so the caller can start again immediately.
    task automatic convert(input int v, input int poke_at, input int poke_val, input bit b2b);
        logic [12:0] ma, mb;
        int n;
        ma = model(v, 1'b1);
        mb = model(v, 1'b0);
        i_bin   = IN_W'(v);
        i_start = 1'b1;
        @(negedge CLK);
        i_start = 1'b0;
        i_bin   = IN_W'($urandom);
        n = 0;
        check("busy_during", 32'(busy_a), 32'd1);
        while (!done_a && n < 40) begin
            @(negedge CLK);
            n++;
            if (n == poke_at) begin
                i_start = 1'b1;
                i_bin   = IN_W'(poke_val);
            end else begin
                i_start = 1'b0;
            end
        end
        i_start = 1'b0;
        check($sformatf("latency(%0d)", v), 32'(n), 32'(LAT));
        check($sformatf("bcd_blz1(%0d)", v), 32'(bcd_a), 32'(ma[11:0]));
        check($sformatf("ovf_blz1(%0d)", v), 32'(ovf_a), 32'(ma[12]));
        check($sformatf("bcd_blz0(%0d)", v), 32'(bcd_b), 32'(mb[11:0]));
        check($sformatf("ovf_blz0(%0d)", v), 32'(ovf_b), 32'(mb[12]));
        check("done_b_aligned", 32'(done_b), 32'd1);
        check("ce_set", 32'(ce_a), 32'd1);
        if (!b2b) begin
            @(negedge CLK);
            check("done_one_cycle", 32'(done_a), 32'd0);
            check("idle_after", 32'(busy_a), 32'd0);
            check("ce_held", 32'(ce_a), 32'd1);
        end
    endtask

    initial begin
        int dones;
        int dir_vals[$] = '{7, 0, -7, -42, 50, 999, 1000, -99, -100, -1024, -5, 1023, 100, 9, -10};

        // Reset state, held and after release with no start.
        #12;
        check("rst_bcd", 32'(bcd_a), 32'hAAA);
        check("rst_bcd_b", 32'(bcd_b), 32'hAAA);
        check("rst_ce", 32'(ce_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("idle_bcd", 32'(bcd_a), 32'hAAA);
        check("idle_ce", 32'(ce_a), 32'd0);
        check("idle_busy", 32'(busy_a), 32'd0);

        convert(123, -1, 0, 1'b0);
        foreach (dir_vals[i]) convert(dir_vals[i], -1, 0, 1'b0);

        // Start ignored mid-conversion, then a back-to-back start in the o_done cycle.
        convert(321, 5, 456, 1'b1);
        convert(456, -1, 0, 1'b0);

        // Asynchronous reset in the middle of a conversion.
        i_bin   = IN_W'(500);
        i_start = 1'b1;
        @(negedge CLK);
        i_start = 1'b0;
        repeat (5) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        check("arst_bcd", 32'(bcd_a), 32'hAAA);
        check("arst_ovf", 32'(ovf_a), 32'd0);
        check("arst_ce", 32'(ce_a), 32'd0);
        check("arst_busy", 32'(busy_a), 32'd0);
        check("arst_done", 32'(done_a), 32'd0);
        dones = 0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (15) begin
            @(negedge CLK);
            if (done_a) dones++;
        end
        check("arst_no_done", 32'(dones), 32'd0);
        check("arst_bcd_kept", 32'(bcd_a), 32'hAAA);
        convert(88, -1, 0, 1'b0);

        // Random values, half of them concentrated near the displayable range.
        for (int k = 0; k < 40; k++) begin
            int v;
            if (k % 2 == 0) v = int'($urandom_range(2047)) - 1024;
            else            v = int'($urandom_range(1120)) - 110;
            convert(v, -1, 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
